// File: rtl/miriscv_lsu_sequencer.sv
// rtl/miriscv_lsu_sequencer.sv - load/store sequencer between execute stage and data bus
//
// Accepts one memory operation at a time and drives it onto the data
// request/grant/response bus. It generates byte enables and lane-shifted
// store data, and returns sign- or zero-extended load data.
//
// Optional feature macro: MIRISCV_LSU_MISALIGNED_EN
//   defined   - misaligned accesses are split into two aligned word transactions
//   undefined - misaligned accesses complete at once with lsu_fault_o, no bus traffic
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   lsu_req_i/we_i/size_i     operation request (size: 0 W, 1 H, 2 B, 3 HU, 4 BU)
//   lsu_addr_i, lsu_wdata_i   byte address, LSB-justified store data
//   lsu_busy_o                operation in flight (through the completion cycle)
//   lsu_valid_o               one-cycle completion pulse
//   lsu_rdata_o, lsu_fault_o  extended load data / fault flag, valid with lsu_valid_o
//   data_req_o, data_gnt_i    bus request held until grant
//   data_addr_o, data_we_o    word-aligned bus address, write flag
//   data_be_o, data_wdata_o   byte enables, lane-shifted store data
//   data_rvalid_i, data_rdata_i  bus response and read data
module miriscv_lsu_sequencer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_size_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   output logic        lsu_busy_o,
   output logic        lsu_valid_o,
   output logic [31:0] lsu_rdata_o,
   output logic        lsu_fault_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ1 = 3'd1,
      RSP1 = 3'd2,
      REQ2 = 3'd3,
      RSP2 = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t      state_q;
   logic [1:0]  off_q;
   logic [2:0]  size_q;

`ifdef MIRISCV_LSU_MISALIGNED_EN
   logic        split_q;
   logic [3:0]  be2_q;
   logic [31:0] wdata2_q;
   logic [31:0] rdata1_q;
   logic [63:0] wsh_c;
`else
   logic [31:0] wsh_c;
`endif

   logic [3:0]  mask_c;
   logic [7:0]  m8_c;
   logic        illegal_c;
   logic        misal_c;
   logic        reject_c;

   // Request decode works only on lsu_*_i and feeds registers, never data_*_o directly.
   always_comb begin
      mask_c    = 4'b0000;
      illegal_c = 1'b0;
      case (lsu_size_i)
         3'd0:       mask_c = 4'b1111;
         3'd1, 3'd3: mask_c = 4'b0011;
         3'd2, 3'd4: mask_c = 4'b0001;
         default:    illegal_c = 1'b1;
      endcase
      m8_c    = {4'b0000, mask_c} << lsu_addr_i[1:0];
      misal_c = |m8_c[7:4];
`ifdef MIRISCV_LSU_MISALIGNED_EN
      // Upper half carries the bytes that spill into the next word.
      wsh_c    = {32'd0, lsu_wdata_i} << {lsu_addr_i[1:0], 3'b000};
      reject_c = illegal_c;
`else
      wsh_c    = lsu_wdata_i << {lsu_addr_i[1:0], 3'b000};
      reject_c = illegal_c | misal_c;
`endif
   end

   // Shift the (second word, first word) pair down by the offset, then extend.
   function automatic logic [31:0] load_result(input logic [2:0]  size,
                                               input logic [63:0] pair,
                                               input logic [1:0]  off);
      logic [31:0] r;
      r = 32'(pair >> {off, 3'b000});
      case (size)
         3'd1:    load_result = {{16{r[15]}}, r[15:0]};
         3'd2:    load_result = {{24{r[7]}}, r[7:0]};
         3'd3:    load_result = {16'd0, r[15:0]};
         3'd4:    load_result = {24'd0, r[7:0]};
         default: load_result = r;
      endcase
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         off_q        <= 2'd0;
         size_q       <= 3'd0;
         lsu_busy_o   <= 1'b0;
         lsu_valid_o  <= 1'b0;
         lsu_rdata_o  <= 32'd0;
         lsu_fault_o  <= 1'b0;
         data_req_o   <= 1'b0;
         data_addr_o  <= 32'd0;
         data_we_o    <= 1'b0;
         data_be_o    <= 4'd0;
         data_wdata_o <= 32'd0;
`ifdef MIRISCV_LSU_MISALIGNED_EN
         split_q      <= 1'b0;
         be2_q        <= 4'd0;
         wdata2_q     <= 32'd0;
         rdata1_q     <= 32'd0;
`endif
      end else begin
         lsu_valid_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (lsu_req_i) begin
                  lsu_busy_o   <= 1'b1;
                  off_q        <= lsu_addr_i[1:0];
                  size_q       <= lsu_size_i;
                  data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                  data_we_o    <= lsu_we_i;
                  data_be_o    <= m8_c[3:0];
                  data_wdata_o <= wsh_c[31:0];
`ifdef MIRISCV_LSU_MISALIGNED_EN
                  split_q      <= misal_c;
                  be2_q        <= m8_c[7:4];
                  wdata2_q     <= wsh_c[63:32];
`endif
                  if (reject_c) begin
                     state_q     <= DONE;
                     lsu_valid_o <= 1'b1;
                     lsu_fault_o <= 1'b1;
                     lsu_rdata_o <= 32'd0;
                  end else begin
                     state_q    <= REQ1;
                     data_req_o <= 1'b1;
                  end
               end
            end
            REQ1: begin
               if (data_gnt_i) begin
                  data_req_o <= 1'b0;
                  state_q    <= RSP1;
               end
            end
            RSP1: begin
               if (data_rvalid_i) begin
`ifdef MIRISCV_LSU_MISALIGNED_EN
                  if (split_q) begin
                     rdata1_q     <= data_rdata_i;
                     state_q      <= REQ2;
                     data_req_o   <= 1'b1;
                     data_addr_o  <= data_addr_o + 32'd4;  // wraps past 0xFFFFFFFC
                     data_be_o    <= be2_q;
                     data_wdata_o <= wdata2_q;
                  end else
`endif
                  begin
                     state_q     <= DONE;
                     lsu_valid_o <= 1'b1;
                     lsu_fault_o <= 1'b0;
                     lsu_rdata_o <= data_we_o ? 32'd0
                                  : load_result(size_q, {32'd0, data_rdata_i}, off_q);
                  end
               end
            end
`ifdef MIRISCV_LSU_MISALIGNED_EN
            REQ2: begin
               if (data_gnt_i) begin
                  data_req_o <= 1'b0;
                  state_q    <= RSP2;
               end
            end
            RSP2: begin
               if (data_rvalid_i) begin
                  state_q     <= DONE;
                  lsu_valid_o <= 1'b1;
                  lsu_fault_o <= 1'b0;
                  lsu_rdata_o <= data_we_o ? 32'd0
                               : load_result(size_q, {data_rdata_i, rdata1_q}, off_q);
               end
            end
`endif
            DONE: begin
               state_q     <= IDLE;
               lsu_busy_o  <= 1'b0;
               lsu_fault_o <= 1'b0;
               lsu_rdata_o <= 32'd0;
            end
            default: begin
               state_q    <= IDLE;
               lsu_busy_o <= 1'b0;
               data_req_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_miriscv_lsu_sequencer.sv
// tb/tb_miriscv_lsu_sequencer.sv - self-checking bench for miriscv_lsu_sequencer
module tb_miriscv_lsu_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [2:0]  lsu_size_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_wdata_i;
   logic        lsu_busy_o;
   logic        lsu_valid_o;
   logic [31:0] lsu_rdata_o;
   logic        lsu_fault_o;
   logic        data_req_o;
   logic        data_gnt_i;
   logic [31:0] data_addr_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;

   always #5 clk_i = ~clk_i;

   miriscv_lsu_sequencer dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
      .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
      .lsu_busy_o(lsu_busy_o), .lsu_valid_o(lsu_valid_o),
      .lsu_rdata_o(lsu_rdata_o), .lsu_fault_o(lsu_fault_o),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
      .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
      .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // observed results of one operation
   int          ntx, lat, stab, berr;
   logic [31:0] a0, a1, w0, w1, res;
   logic [3:0]  b0, b1;
   logic        we0, we1, flt;

   // reference model results
   int          entx;
   logic [31:0] ea0, ea1, ew0, ew1, eres;
   logic [3:0]  eb0, eb1;
   logic        ef;

   // Byte-level reference: each accessed byte lands in the word that holds it.
   task automatic model(input logic we, input logic [2:0] size, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd0, input logic [31:0] rd1);
      int n;
      logic [31:0] w_first, last, ba, val;
      logic [7:0] bt;
      bit spans;
      entx = 0; ea0 = 0; ea1 = 0; eb0 = 0; eb1 = 0; ew0 = 0; ew1 = 0; ef = 0; eres = 0;
      n = (size == 3'd0) ? 4 : (size == 3'd1 || size == 3'd3) ? 2 :
          (size == 3'd2 || size == 3'd4) ? 1 : 0;
      if (n == 0) begin ef = 1; return; end
      w_first = a & 32'hFFFF_FFFC;
      last    = a + 32'(n) - 32'd1;
      spans   = (last & 32'hFFFF_FFFC) != w_first;
`ifndef MIRISCV_LSU_MISALIGNED_EN
      if (spans) begin ef = 1; return; end
`endif
      entx = spans ? 2 : 1;
      ea0 = w_first;
      if (spans) ea1 = w_first + 32'd4;
      val = 0;
      for (int i = 0; i < n; i++) begin
         ba = a + 32'(i);
         if ((ba & 32'hFFFF_FFFC) != w_first) begin
            eb1[ba[1:0]] = 1'b1;
            ew1[ba[1:0]*8 +: 8] = wd[i*8 +: 8];
            bt = rd1[ba[1:0]*8 +: 8];
         end else begin
            eb0[ba[1:0]] = 1'b1;
            ew0[ba[1:0]*8 +: 8] = wd[i*8 +: 8];
            bt = rd0[ba[1:0]*8 +: 8];
         end
         val[i*8 +: 8] = bt;
      end
      if (size == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
      if (size == 3'd2 && val[7])  val = val | 32'hFFFF_FF00;
      eres = we ? 32'd0 : val;
   endtask

   // Drives one operation and plays the bus slave: grant after gdly cycles of
   // request, response rdly cycles after the cycle following the grant.
   task automatic do_op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd0, input logic [31:0] rd1,
                        input int gdly, input int rdly);
      int gw, rw;
      bit pend, seen;
      logic [31:0] sa, sw;
      logic [3:0] sb;
      ntx = 0; lat = 0; stab = 0; berr = 0;
      a0 = 0; a1 = 0; w0 = 0; w1 = 0; b0 = 0; b1 = 0; we0 = 0; we1 = 0; res = 0; flt = 0;
      sa = 0; sw = 0; sb = 0; rw = 0;
      lsu_req_i = 1; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; lsu_wdata_i = wd;
      data_gnt_i = 0; data_rvalid_i = 0;
      @(posedge clk_i); #1;
      lsu_req_i = 0; lsu_wdata_i = $urandom; lsu_addr_i = $urandom;
      gw = gdly; pend = 0; seen = 0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = $urandom;
         if (!lsu_busy_o) berr++;
         if (lsu_valid_o) begin
            lat = cyc; res = lsu_rdata_o; flt = lsu_fault_o;
            break;
         end
         if (pend) begin
            if (rw == 0) begin
               data_rvalid_i = 1;
               data_rdata_i = (ntx == 1) ? rd0 : rd1;
               pend = 0;
            end else rw--;
         end else if (data_req_o) begin
            if (!seen) begin
               sa = data_addr_o; sb = data_be_o; sw = data_wdata_o; seen = 1;
            end else if (data_addr_o !== sa || data_be_o !== sb || data_wdata_o !== sw) stab++;
            if (gw == 0) begin
               data_gnt_i = 1;
               if (ntx == 0) begin a0 = data_addr_o; b0 = data_be_o; w0 = data_wdata_o; we0 = data_we_o; end
               if (ntx == 1) begin a1 = data_addr_o; b1 = data_be_o; w1 = data_wdata_o; we1 = data_we_o; end
               ntx++; pend = 1; rw = rdly; gw = gdly; seen = 0;
            end else gw--;
         end
         @(posedge clk_i); #1;
      end
      data_gnt_i = 0; data_rvalid_i = 0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset();
      rst_i = 1; lsu_req_i = 0; lsu_we_i = 0; lsu_size_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0;
      data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
      repeat (2) @(posedge clk_i);
      #1;
      n_cmp++; if ({lsu_busy_o, lsu_valid_o, lsu_fault_o, data_req_o, data_we_o} !== 5'd0) begin
         n_bad++; $display("FAIL reset_flags: got %b expected 00000",
                           {lsu_busy_o, lsu_valid_o, lsu_fault_o, data_req_o, data_we_o}); end
      n_cmp++; if (lsu_rdata_o !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", lsu_rdata_o); end
      n_cmp++; if (data_addr_o !== 32'd0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", data_addr_o); end
      n_cmp++; if (data_be_o !== 4'd0) begin n_bad++; $display("FAIL reset_be: got %b expected 0", data_be_o); end
      n_cmp++; if (data_wdata_o !== 32'd0) begin n_bad++; $display("FAIL reset_wdata: got %h expected 0", data_wdata_o); end
      rst_i = 0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_word_load();
      do_op(0, 3'd0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0);
      n_cmp++; if (b0 !== 4'b1111) begin n_bad++; $display("FAIL lw_be: got %b expected 1111", b0); end
      n_cmp++; if (a0 !== 32'h100) begin n_bad++; $display("FAIL lw_addr: got %h expected 100", a0); end
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL lw_latency: got %0d expected 3", lat); end
      n_cmp++; if (res !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_rdata: got %h expected deadbeef", res); end
   endtask

   task automatic test_byte_load();
      do_op(0, 3'd2, 32'h103, 32'h0, 32'h80FF_FFFF, 32'h0, 0, 0);
      n_cmp++; if (b0 !== 4'b1000) begin n_bad++; $display("FAIL lb_be: got %b expected 1000", b0); end
      n_cmp++; if (res !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_rdata: got %h expected ffffff80", res); end
      do_op(0, 3'd4, 32'h103, 32'h0, 32'h80FF_FFFF, 32'h0, 0, 0);
      n_cmp++; if (res !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_rdata: got %h expected 00000080", res); end
   endtask

   task automatic test_store_stall();
      do_op(1, 3'd1, 32'h102, 32'h0000_1234, 32'h5555_AAAA, 32'h0, 3, 0);
      n_cmp++; if (a0 !== 32'h100) begin n_bad++; $display("FAIL sh_addr: got %h expected 100", a0); end
      n_cmp++; if (b0 !== 4'b1100) begin n_bad++; $display("FAIL sh_be: got %b expected 1100", b0); end
      n_cmp++; if (w0 !== 32'h1234_0000) begin n_bad++; $display("FAIL sh_wdata: got %h expected 12340000", w0); end
      n_cmp++; if (we0 !== 1'b1) begin n_bad++; $display("FAIL sh_we: got %b expected 1", we0); end
      n_cmp++; if (stab !== 0) begin n_bad++; $display("FAIL sh_stable: got %0d changes expected 0", stab); end
      n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL sh_latency: got %0d expected 6", lat); end
      n_cmp++; if (res !== 32'd0) begin n_bad++; $display("FAIL sh_rdata: got %h expected 0", res); end
   endtask

   task automatic test_misaligned();
      do_op(0, 3'd0, 32'h1FE, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 0, 0);
`ifdef MIRISCV_LSU_MISALIGNED_EN
      n_cmp++; if (ntx !== 2) begin n_bad++; $display("FAIL mis_ntx: got %0d expected 2", ntx); end
      n_cmp++; if ({a0, a1} !== {32'h1FC, 32'h200}) begin n_bad++; $display("FAIL mis_addr: got %h/%h expected 1fc/200", a0, a1); end
      n_cmp++; if ({b0, b1} !== 8'b1100_0011) begin n_bad++; $display("FAIL mis_be: got %b/%b expected 1100/0011", b0, b1); end
      n_cmp++; if (res !== 32'h3344_AABB) begin n_bad++; $display("FAIL mis_rdata: got %h expected 3344aabb", res); end
      n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL mis_latency: got %0d expected 5", lat); end
      do_op(1, 3'd0, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 0);
      n_cmp++; if ({a0, a1} !== {32'hFFFF_FFFC, 32'h0}) begin n_bad++; $display("FAIL wrap_addr: got %h/%h expected fffffffc/0", a0, a1); end
      n_cmp++; if ({b0, b1} !== 8'b1000_0111) begin n_bad++; $display("FAIL wrap_be: got %b/%b expected 1000/0111", b0, b1); end
      n_cmp++; if ({w0[31:24], w1[23:0]} !== 32'h0D_CAFEF0) begin n_bad++; $display("FAIL wrap_wdata: got %h/%h", w0, w1); end
`else
      n_cmp++; if (flt !== 1'b1) begin n_bad++; $display("FAIL mis_fault: got %b expected 1", flt); end
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL mis_latency: got %0d expected 1", lat); end
      n_cmp++; if (ntx !== 0) begin n_bad++; $display("FAIL mis_no_bus: got %0d requests expected 0", ntx); end
      do_op(1, 3'd0, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 0);
      n_cmp++; if ({flt, res} !== {1'b1, 32'd0}) begin n_bad++; $display("FAIL wrap_fault: got %b/%h expected 1/0", flt, res); end
`endif
   endtask

   task automatic test_illegal_size();
      do_op(0, 3'd6, 32'h100, 32'h0, 32'hFFFF_FFFF, 32'h0, 0, 0);
      n_cmp++; if (flt !== 1'b1) begin n_bad++; $display("FAIL ill_fault: got %b expected 1", flt); end
      n_cmp++; if (res !== 32'd0) begin n_bad++; $display("FAIL ill_rdata: got %h expected 0", res); end
      n_cmp++; if (lat !== 1 || ntx !== 0) begin n_bad++; $display("FAIL ill_timing: got lat %0d ntx %0d expected 1/0", lat, ntx); end
   endtask

   task automatic test_reset_mid();
      int spurious;
      lsu_req_i = 1; lsu_we_i = 0; lsu_size_i = 3'd0; lsu_addr_i = 32'h100;
      @(posedge clk_i); #1;
      lsu_req_i = 0;
      n_cmp++; if (data_req_o !== 1'b1) begin n_bad++; $display("FAIL rmid_req: got %b expected 1", data_req_o); end
      data_gnt_i = 1;
      @(posedge clk_i); #1;
      data_gnt_i = 0; rst_i = 1;
      @(posedge clk_i); #1;
      rst_i = 0;
      n_cmp++; if ({data_req_o, lsu_busy_o, lsu_valid_o} !== 3'b000) begin
         n_bad++; $display("FAIL rmid_idle: got req/busy/valid %b expected 000", {data_req_o, lsu_busy_o, lsu_valid_o}); end
      data_rvalid_i = 1; data_rdata_i = 32'h1234_5678;
      spurious = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_i); #1;
         data_rvalid_i = 0;
         if (lsu_valid_o !== 1'b0 || lsu_busy_o !== 1'b0) spurious++;
      end
      n_cmp++; if (spurious !== 0) begin n_bad++; $display("FAIL rmid_late_rvalid: got %0d active cycles expected 0", spurious); end
      do_op(0, 3'd3, 32'h202, 32'h0, 32'h9876_0000, 32'h0, 1, 1);
      n_cmp++; if (res !== 32'h0000_9876) begin n_bad++; $display("FAIL rmid_recover: got %h expected 00009876", res); end
   endtask

   task automatic test_random(input int n_ops, input int maxd);
      logic we;
      logic [2:0] size;
      logic [31:0] addr, wd, rd0, rd1, m;
      int gd, rdl, elat;
      for (int k = 0; k < n_ops; k++) begin
         we   = 1'($urandom);
         size = ($urandom_range(0, 7) == 0) ? 3'(5 + $urandom_range(0, 2)) : 3'($urandom_range(0, 4));
         addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
         wd = $urandom; rd0 = $urandom; rd1 = $urandom;
         gd = $urandom_range(0, maxd); rdl = $urandom_range(0, maxd);
         model(we, size, addr, wd, rd0, rd1);
         do_op(we, size, addr, wd, rd0, rd1, gd, rdl);
         elat = 1 + entx * (gd + rdl + 2);
         n_cmp++; if (flt !== ef) begin n_bad++; $display("FAIL rnd_fault: op %0d got %b expected %b", k, flt, ef); end
         n_cmp++; if (res !== eres) begin n_bad++; $display("FAIL rnd_rdata: op %0d got %h expected %h", k, res, eres); end
         n_cmp++; if (lat !== elat) begin n_bad++; $display("FAIL rnd_latency: op %0d got %0d expected %0d", k, lat, elat); end
         n_cmp++; if (ntx !== entx) begin n_bad++; $display("FAIL rnd_ntx: op %0d got %0d expected %0d", k, ntx, entx); end
         n_cmp++; if (stab !== 0 || berr !== 0) begin n_bad++; $display("FAIL rnd_hold: op %0d got %0d/%0d expected 0/0", k, stab, berr); end
         if (entx >= 1) begin
            n_cmp++; if ({a0, b0, we0} !== {ea0, eb0, we}) begin n_bad++;
               $display("FAIL rnd_txn0: op %0d got %h %b %b expected %h %b %b", k, a0, b0, we0, ea0, eb0, we); end
            m = {{8{eb0[3]}}, {8{eb0[2]}}, {8{eb0[1]}}, {8{eb0[0]}}};
            if (we) begin
               n_cmp++; if ((w0 & m) !== ew0) begin n_bad++; $display("FAIL rnd_wdata0: op %0d got %h expected %h", k, w0 & m, ew0); end
            end
         end
         if (entx == 2) begin
            n_cmp++; if ({a1, b1, we1} !== {ea1, eb1, we}) begin n_bad++;
               $display("FAIL rnd_txn1: op %0d got %h %b %b expected %h %b %b", k, a1, b1, we1, ea1, eb1, we); end
            m = {{8{eb1[3]}}, {8{eb1[2]}}, {8{eb1[1]}}, {8{eb1[0]}}};
            if (we) begin
               n_cmp++; if ((w1 & m) !== ew1) begin n_bad++; $display("FAIL rnd_wdata1: op %0d got %h expected %h", k, w1 & m, ew1); end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addr, rd0, rd1;
      logic [2:0] size;
      for (int k = 0; k < 12; k++) begin
         size = 3'($urandom_range(0, 4));
         addr = $urandom; rd0 = $urandom; rd1 = $urandom;
         model(1'b0, size, addr, 32'h0, rd0, rd1);
         do_op(1'b0, size, addr, 32'h0, rd0, rd1, 0, 0);
         n_cmp++; if ({flt, res} !== {ef, eres} || lat !== 1 + entx * 2) begin n_bad++;
            $display("FAIL b2b: op %0d got %b %h lat %0d expected %b %h lat %0d", k, flt, res, lat, ef, eres, 1 + entx * 2); end
      end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_load();
      test_store_stall();
      test_misaligned();
      test_illegal_size();
      test_reset_mid();
      test_random(60, 3);
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
